// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider.
// One WIDTH+1-bit subtract per clock; quotient/remainder land after WIDTH
// iterations. A zero divisor short-circuits to all-ones / dividend with a flag.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] prem;      // partial remainder R
    logic [WIDTH-1:0] qsh;       // quotient shift register Q (holds dividend for /0)
    logic [WIDTH-1:0] dvsr;
    logic [CW-1:0]    cnt;
    logic             dz_pend;   // accepted op had a zero divisor

    logic [WIDTH+1:0] sum;
    logic             no_borrow;
    logic             unused_msb;
    logic [WIDTH-1:0] prem_nxt;
    logic [WIDTH-1:0] qsh_nxt;

    assign ready = (state == IDLE);
    assign valid = (state == DONE);

    // One restoring step: trial subtract via inverted operand + carry-in,
    // keep the difference only when the subtract did not borrow.
    always_comb begin
        sum       = {1'b0, prem, qsh[WIDTH-1]} + {1'b0, 1'b1, ~dvsr}
                  + {{(WIDTH+1){1'b0}}, 1'b1};
        no_borrow = sum[WIDTH+1];
        // Bit WIDTH of the difference is always 0 when kept (R < divisor).
        unused_msb = sum[WIDTH];
        if (no_borrow) begin
            prem_nxt = sum[WIDTH-1:0];
            qsh_nxt  = {qsh[WIDTH-2:0], 1'b1};
        end else begin
            prem_nxt = {prem[WIDTH-2:0], qsh[WIDTH-1]};
            qsh_nxt  = {qsh[WIDTH-2:0], 1'b0};
        end
    end

    // Control FSM and datapath registers; results only move on entry to DONE.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state       <= IDLE;
            prem        <= '0;
            qsh         <= '0;
            dvsr        <= '0;
            cnt         <= '0;
            dz_pend     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        prem    <= '0;
                        qsh     <= dividend;
                        dvsr    <= divisor;
                        cnt     <= '0;
                        dz_pend <= (divisor == '0);
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (dz_pend) begin
                        // Zero divisor: skip iterating, publish the fixed result.
                        quotient    <= '1;
                        remainder   <= qsh;
                        div_by_zero <= 1'b1;
                        state       <= DONE;
                    end else begin
                        prem <= prem_nxt;
                        qsh  <= qsh_nxt;
                        cnt  <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1)) begin
                            quotient    <= qsh_nxt;
                            remainder   <= prem_nxt;
                            div_by_zero <= 1'b0;
                            state       <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: vector table + hand sequences + random ops vs. arithmetic model.
module tb_seq_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rstb = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         ready, valid, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rstb(rstb), .start(start),
        .dividend(dividend), .divisor(divisor),
        .ready(ready), .valid(valid),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    typedef struct {
        logic [W-1:0] n;
        logic [W-1:0] d;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Plain arithmetic reference, with the zero-divisor convention.
    task automatic model(input logic [W-1:0] n, input logic [W-1:0] d,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        if (d == 0) begin
            q = '1; r = n; z = 1'b1;
        end else begin
            q = n / d; r = n % d; z = 1'b0;
        end
    endtask

    // Issue one op; inj>=0 pulses start with 9/2 at that cycle of the busy window.
    task automatic run_op(input logic [W-1:0] n, input logic [W-1:0] d, input int inj,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic z,
                          output int lat, output bit stab, output bit pulse);
        int guard;
        logic [W-1:0] q0, r0;
        logic z0;
        guard = 0;
        while (!ready && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        start = 1'b1; dividend = n; divisor = d;
        @(posedge clk); #1;
        start = 1'b0;
        q0 = quotient; r0 = remainder; z0 = div_by_zero;
        stab = 1'b1; lat = 0;
        while (!valid && lat < 100) begin
            if (quotient !== q0 || remainder !== r0 || div_by_zero !== z0 || ready !== 1'b0)
                stab = 1'b0;
            if (lat == inj) begin
                start = 1'b1; dividend = 9; divisor = 2;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1; lat++;
        end
        start = 1'b0;
        q = quotient; r = remainder; z = div_by_zero;
        @(posedge clk); #1;
        pulse = (valid === 1'b0) && (ready === 1'b1);
    endtask

    task automatic do_check(input string name, input logic [W-1:0] n, input logic [W-1:0] d,
                            input int inj, input bit algebra);
        logic [W-1:0] q, r, eq, er;
        logic z, ez;
        int lat;
        bit stab, pulse;
        model(n, d, eq, er, ez);
        run_op(n, d, inj, q, r, z, lat, stab, pulse);
        chk({name, "_q"}, q, eq);
        chk({name, "_r"}, r, er);
        chk({name, "_dz"}, z, ez);
        chk({name, "_lat"}, lat, (d == 0) ? 1 : W);
        chk({name, "_stable"}, stab, 1);
        chk({name, "_pulse"}, pulse, 1);
        if (algebra && d != 0) begin
            chk({name, "_qdr"}, 64'(q) * 64'(d) + 64'(r), 64'(n));
            chk({name, "_rltd"}, r < d, 1);
        end
    endtask

    initial begin
        // Expected values written out by hand for the directed table.
        tbl.push_back('{n: 100,          d: 7,            q: 14,           r: 2,            z: 0});
        tbl.push_back('{n: 32'hFFFFFFFF, d: 1,            q: 32'hFFFFFFFF, r: 0,            z: 0});
        tbl.push_back('{n: 5,            d: 9,            q: 0,            r: 5,            z: 0});
        tbl.push_back('{n: 32'h80000000, d: 32'hFFFFFFFF, q: 0,            r: 32'h80000000, z: 0});
        tbl.push_back('{n: 32'hFFFFFFFF, d: 32'hFFFFFFFF, q: 1,            r: 0,            z: 0});
        tbl.push_back('{n: 42,           d: 0,            q: 32'hFFFFFFFF, r: 42,           z: 1});
        tbl.push_back('{n: 42,           d: 6,            q: 7,            r: 0,            z: 0});
        tbl.push_back('{n: 0,            d: 0,            q: 32'hFFFFFFFF, r: 0,            z: 1});
        tbl.push_back('{n: 0,            d: 5,            q: 0,            r: 0,            z: 0});
        tbl.push_back('{n: 1000,         d: 3,            q: 333,          r: 1,            z: 0});

        // Reset state while rstb is held low.
        #2;
        chk("rst_ready", ready, 1);
        chk("rst_valid", valid, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dz", div_by_zero, 0);
        @(posedge clk); #1;
        rstb = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", ready, 1);

        // Directed table.
        foreach (tbl[i]) begin
            logic [W-1:0] q, r;
            logic z;
            int lat;
            bit stab, pulse;
            run_op(tbl[i].n, tbl[i].d, -1, q, r, z, lat, stab, pulse);
            chk($sformatf("tbl%0d_q", i), q, tbl[i].q);
            chk($sformatf("tbl%0d_r", i), r, tbl[i].r);
            chk($sformatf("tbl%0d_dz", i), z, tbl[i].z);
            chk($sformatf("tbl%0d_lat", i), lat, (tbl[i].d == 0) ? 1 : W);
            chk($sformatf("tbl%0d_stable", i), stab, 1);
            chk($sformatf("tbl%0d_pulse", i), pulse, 1);
        end

        // Reset mid-RUN: previous results (333 r1) must clear asynchronously.
        start = 1'b1; dividend = 1000; divisor = 3;
        @(posedge clk); #1;
        start = 1'b0;
        chk("mid_busy", ready, 0);
        repeat (9) @(posedge clk);
        #2;
        rstb = 1'b0;
        #1;
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_q", quotient, 0);
        chk("mid_rst_r", remainder, 0);
        chk("mid_rst_dz", div_by_zero, 0);
        @(posedge clk); #1;
        rstb = 1'b1;
        do_check("restart", 1000, 3, -1, 1'b1);

        // Busy protection: a start pulse mid-RUN is ignored and not queued.
        do_check("busy", 100, 7, 5, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_not_queued", ready, 1);

        // start held high: a result every WIDTH+2 cycles.
        begin
            int t, first, second;
            t = 0; first = -1; second = -1;
            start = 1'b1; dividend = 100; divisor = 7;
            while (second < 0 && t < 200) begin
                @(posedge clk); #1; t++;
                if (valid) begin
                    if (first < 0) first = t;
                    else second = t;
                end
            end
            start = 1'b0;
            chk("b2b_period", second - first, W + 2);
            chk("b2b_q", quotient, 14);
            repeat (40) @(posedge clk);
            #1;
        end

        // Random operands, ~10% zero divisors, spread of divisor magnitudes.
        for (int k = 0; k < 1500; k++) begin
            logic [W-1:0] n, d;
            n = $urandom;
            d = $urandom >> $urandom_range(0, W - 1);
            if ($urandom_range(0, 9) == 0) d = 0;
            do_check($sformatf("rnd%0d", k), n, d, -1, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
